// File: rtl/hazard_controller_pkg.sv
// Shared pipeline definitions for the hazard controller: state encoding,
// opcode constants and register-file geometry.
package hazard_controller_pkg;

    localparam int unsigned REGISTER_DEPTH = 32;
    localparam int unsigned REG_W          = $clog2(REGISTER_DEPTH);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef logic [REG_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        RUN,
        LOAD_BUBBLE,
        MEM_WAIT,
        FLUSH
    } hazard_state_t;

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline-status inputs and stage-control outputs of the hazard controller.
// The slave modport is the controller's view; master is the pipeline's view.
interface hazard_controller_if;
    import hazard_controller_pkg::*;

    logic     dec_valid;
    reg_idx_t dec_rs1;
    reg_idx_t dec_rs2;
    logic     dec_uses_rs1;
    logic     dec_uses_rs2;
    logic     ex_valid;
    logic [6:0] ex_opcode;
    reg_idx_t ex_rd;
    logic     ex_redirect;
    logic     mem_load_pending;
    logic     mem_rvalid;

    logic     stall_fetch;
    logic     stall_decode;
    logic     stall_execute;
    logic     bubble_execute;
    logic     bubble_writeback;
    logic     flush_fetch;
    logic     flush_decode;
    logic     redirect_fire;
    logic     mem_timeout_error;

    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_uses_rs1, dec_uses_rs2,
        output ex_valid, ex_opcode, ex_rd, ex_redirect,
        output mem_load_pending, mem_rvalid,
        input  stall_fetch, stall_decode, stall_execute,
        input  bubble_execute, bubble_writeback,
        input  flush_fetch, flush_decode, redirect_fire, mem_timeout_error
    );

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_uses_rs1, dec_uses_rs2,
        input  ex_valid, ex_opcode, ex_rd, ex_redirect,
        input  mem_load_pending, mem_rvalid,
        output stall_fetch, stall_decode, stall_execute,
        output bubble_execute, bubble_writeback,
        output flush_fetch, flush_decode, redirect_fire, mem_timeout_error
    );

endinterface

// File: rtl/hazard_controller_perf_counters.sv
// Saturating 32-bit event counters for stall cycles, load-use bubbles and
// redirects. Only instantiated when HAZARD_PERF_COUNTERS_EN is defined.
module hazard_perf_counters (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall_fetch,
    input  logic        i_bubble_execute,
    input  logic        i_redirect_fire,
    output logic [31:0] o_perf_stall_cycles,
    output logic [31:0] o_perf_bubbles,
    output logic [31:0] o_perf_flushes
);

    logic [31:0] r_stall_cycles;
    logic [31:0] r_bubbles;
    logic [31:0] r_flushes;

    // Count each qualifying cycle, holding at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_bubbles      <= '0;
            r_flushes      <= '0;
        end else begin
            if (i_stall_fetch && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (i_bubble_execute && (r_bubbles != '1))
                r_bubbles <= r_bubbles + 32'd1;
            if (i_redirect_fire && (r_flushes != '1))
                r_flushes <= r_flushes + 32'd1;
        end
    end

    assign o_perf_stall_cycles = r_stall_cycles;
    assign o_perf_bubbles      = r_bubbles;
    assign o_perf_flushes      = r_flushes;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use bubbles, memory-wait freezes and
// multi-cycle flushes on redirects. Optional feature macro:
// HAZARD_PERF_COUNTERS_EN adds the perf_* counter outputs.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int unsigned FLUSH_DEPTH = 1,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_controller_if.slave   hz
`ifdef HAZARD_PERF_COUNTERS_EN
    ,
    output logic [31:0]          perf_stall_cycles,
    output logic [31:0]          perf_bubbles,
    output logic [31:0]          perf_flushes
`endif
);

    hazard_state_t r_state;
    hazard_state_t r_saved_state;
    hazard_state_t w_eff_state;
    hazard_state_t w_next_state;
    hazard_state_t w_next_saved;
    logic [3:0]    r_flush_cnt;
    logic [3:0]    w_next_flush_cnt;
    logic [15:0]   r_wait_cnt;
    logic          r_timeout_err;
    logic          w_mem_stall;
    logic          w_load_use;

    assign w_mem_stall = hz.mem_load_pending && !hz.mem_rvalid;

    assign w_load_use = hz.dec_valid && hz.ex_valid && (hz.ex_opcode == OP_LOAD) &&
                        (hz.ex_rd != '0) &&
                        ((hz.dec_uses_rs1 && (hz.dec_rs1 == hz.ex_rd)) ||
                         (hz.dec_uses_rs2 && (hz.dec_rs2 == hz.ex_rd)));

    // Releasing MEM_WAIT acts as the saved state in the same cycle, so a
    // deferred redirect or pending flush proceeds without an extra bubble.
    assign w_eff_state = (r_state == MEM_WAIT) ? r_saved_state : r_state;

    // Next-state and stage controls; the memory stall overrides everything.
    always_comb begin
        w_next_state        = w_eff_state;
        w_next_saved        = r_saved_state;
        w_next_flush_cnt    = r_flush_cnt;
        hz.stall_fetch      = 1'b0;
        hz.stall_decode     = 1'b0;
        hz.stall_execute    = 1'b0;
        hz.bubble_execute   = 1'b0;
        hz.bubble_writeback = 1'b0;
        hz.flush_fetch      = 1'b0;
        hz.flush_decode     = 1'b0;
        hz.redirect_fire    = 1'b0;
        if (w_mem_stall) begin
            hz.stall_fetch      = 1'b1;
            hz.stall_decode     = 1'b1;
            hz.stall_execute    = 1'b1;
            hz.bubble_writeback = 1'b1;
            w_next_state        = MEM_WAIT;
            w_next_saved        = w_eff_state;
        end else begin
            case (w_eff_state)
                RUN: begin
                    if (hz.ex_redirect) begin
                        hz.redirect_fire = 1'b1;
                        hz.flush_fetch   = 1'b1;
                        hz.flush_decode  = 1'b1;
                        if (FLUSH_DEPTH > 1) begin
                            w_next_state     = FLUSH;
                            w_next_flush_cnt = 4'(FLUSH_DEPTH - 1);
                        end
                    end else if (w_load_use) begin
                        hz.stall_fetch    = 1'b1;
                        hz.stall_decode   = 1'b1;
                        hz.bubble_execute = 1'b1;
                        w_next_state      = LOAD_BUBBLE;
                    end
                end
                LOAD_BUBBLE: w_next_state = RUN;
                FLUSH: begin
                    hz.flush_fetch  = 1'b1;
                    hz.flush_decode = 1'b1;
                    if (r_flush_cnt <= 4'd1) begin
                        w_next_state     = RUN;
                        w_next_flush_cnt = '0;
                    end else begin
                        w_next_flush_cnt = r_flush_cnt - 4'd1;
                    end
                end
                default: w_next_state = RUN;
            endcase
        end
        if (rst) begin
            hz.stall_fetch      = 1'b0;
            hz.stall_decode     = 1'b0;
            hz.stall_execute    = 1'b0;
            hz.bubble_execute   = 1'b0;
            hz.bubble_writeback = 1'b0;
            hz.flush_fetch      = 1'b0;
            hz.flush_decode     = 1'b0;
            hz.redirect_fire    = 1'b0;
        end
    end

    // State, saved-state and flush down-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= RUN;
            r_saved_state <= RUN;
            r_flush_cnt   <= '0;
        end else begin
            r_state       <= w_next_state;
            r_saved_state <= w_next_saved;
            r_flush_cnt   <= w_next_flush_cnt;
        end
    end

    // Load wait counter and sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else if (w_mem_stall) begin
            if (r_wait_cnt != '1)
                r_wait_cnt <= r_wait_cnt + 16'd1;
            if (r_wait_cnt >= 16'(MEM_TIMEOUT - 1))
                r_timeout_err <= 1'b1;
        end else begin
            r_wait_cnt <= '0;
        end
    end

    assign hz.mem_timeout_error = r_timeout_err;

`ifdef HAZARD_PERF_COUNTERS_EN
    hazard_perf_counters u_perf (
        .clk                 (clk),
        .rst                 (rst),
        .i_stall_fetch       (hz.stall_fetch),
        .i_bubble_execute    (hz.bubble_execute),
        .i_redirect_fire     (hz.redirect_fire),
        .o_perf_stall_cycles (perf_stall_cycles),
        .o_perf_bubbles      (perf_bubbles),
        .o_perf_flushes      (perf_flushes)
    );
`else
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller (FLUSH_DEPTH=3, MEM_TIMEOUT=8).
// Expected control vectors are queued as stimulus is applied and compared
// mid-cycle. Honours HAZARD_PERF_COUNTERS_EN when defined.
module tb_hazard_controller;
    import hazard_controller_pkg::*;

    // Control vector bit positions: {sf, sd, se, be, bw, ff, fd, rf, err}
    localparam logic [8:0] SF  = 9'b100000000;
    localparam logic [8:0] SD  = 9'b010000000;
    localparam logic [8:0] SE  = 9'b001000000;
    localparam logic [8:0] BE  = 9'b000100000;
    localparam logic [8:0] BW  = 9'b000010000;
    localparam logic [8:0] FF  = 9'b000001000;
    localparam logic [8:0] FD  = 9'b000000100;
    localparam logic [8:0] RF  = 9'b000000010;
    localparam logic [8:0] ER  = 9'b000000001;
    localparam logic [8:0] NONE = 9'b000000000;
    localparam logic [8:0] E_LU = SF | SD | BE;
    localparam logic [8:0] E_MS = SF | SD | SE | BW;
    localparam logic [8:0] E_FL = FF | FD;
    localparam logic [8:0] E_RD = FF | FD | RF;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   exp_stall = 0;
    int   exp_bub   = 0;
    int   exp_fl    = 0;

    logic [8:0] exp_q[$];
    string      tag_q[$];

    hazard_controller_if hz ();

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_bubbles;
    logic [31:0] perf_flushes;
`endif

    hazard_controller #(
        .FLUSH_DEPTH (3),
        .MEM_TIMEOUT (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
`ifdef HAZARD_PERF_COUNTERS_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_bubbles      (perf_bubbles),
        .perf_flushes      (perf_flushes)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] observe();
        return {hz.stall_fetch, hz.stall_decode, hz.stall_execute,
                hz.bubble_execute, hz.bubble_writeback,
                hz.flush_fetch, hz.flush_decode, hz.redirect_fire,
                hz.mem_timeout_error};
    endfunction

    task automatic clear_inputs();
        hz.dec_valid        = 1'b0;
        hz.dec_rs1          = '0;
        hz.dec_rs2          = '0;
        hz.dec_uses_rs1     = 1'b0;
        hz.dec_uses_rs2     = 1'b0;
        hz.ex_valid         = 1'b0;
        hz.ex_opcode        = OP_OP;
        hz.ex_rd            = '0;
        hz.ex_redirect      = 1'b0;
        hz.mem_load_pending = 1'b0;
        hz.mem_rvalid       = 1'b0;
    endtask

    task automatic set_ex(input logic [6:0] op, input int unsigned rd);
        hz.ex_valid  = 1'b1;
        hz.ex_opcode = op;
        hz.ex_rd     = reg_idx_t'(rd);
    endtask

    task automatic set_dec(input int unsigned rs1, input logic u1,
                           input int unsigned rs2, input logic u2);
        hz.dec_valid    = 1'b1;
        hz.dec_rs1      = reg_idx_t'(rs1);
        hz.dec_uses_rs1 = u1;
        hz.dec_rs2      = reg_idx_t'(rs2);
        hz.dec_uses_rs2 = u2;
    endtask

    // Queue the expectation for the current cycle, compare mid-cycle, then
    // advance to just after the next rising edge.
    task automatic step(input logic [8:0] e, input string tag);
        logic [8:0] got;
        logic [8:0] want;
        string      t;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        got  = observe();
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", t, got, want);
        end
        if (rst) begin
            exp_stall = 0;
            exp_bub   = 0;
            exp_fl    = 0;
        end else begin
            if (want[8]) exp_stall++;
            if (want[5]) exp_bub++;
            if (want[1]) exp_fl++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        step(NONE, "reset_outputs");
        rst = 1'b0;

        // Load-use via rs1: one stall cycle, one quiet bubble cycle.
        set_ex(OP_LOAD, 5);
        set_dec(5, 1'b1, 0, 1'b0);
        step(E_LU, "loaduse_rs1_stall");
        hz.ex_valid = 1'b0;
        step(NONE, "loaduse_bubble_quiet");
        clear_inputs();
        step(NONE, "loaduse_back_run");

        // Load to x0 never stalls.
        set_ex(OP_LOAD, 0);
        set_dec(0, 1'b1, 0, 1'b1);
        step(NONE, "loaduse_rd0");

        // rs2 matches but is not read.
        set_ex(OP_LOAD, 5);
        set_dec(3, 1'b1, 5, 1'b0);
        step(NONE, "no_false_stall_rs2");

        // rs2 matches and is read.
        hz.dec_uses_rs2 = 1'b1;
        step(E_LU, "loaduse_rs2_stall");
        hz.ex_valid = 1'b0;
        step(NONE, "loaduse_rs2_bubble");
        clear_inputs();

        // Non-load producer never stalls.
        set_ex(OP_OP, 5);
        set_dec(5, 1'b1, 5, 1'b1);
        step(NONE, "alu_producer_no_stall");
        clear_inputs();

        // Memory wait: pending 4 cycles, data on the 4th.
        hz.mem_load_pending = 1'b1;
        for (int unsigned i = 0; i < 3; i++) step(E_MS, "memwait_stall");
        hz.mem_rvalid = 1'b1;
        step(NONE, "memwait_release");
        clear_inputs();
        step(NONE, "memwait_after");

        // Data in the same cycle the load appears.
        hz.mem_load_pending = 1'b1;
        hz.mem_rvalid       = 1'b1;
        step(NONE, "memwait_same_cycle");
        clear_inputs();

        // Redirect with simultaneous load-use: 3 flush cycles, no bubble.
        set_ex(OP_LOAD, 5);
        set_dec(5, 1'b1, 0, 1'b0);
        hz.ex_redirect = 1'b1;
        step(E_RD, "redirect_fire");
        hz.ex_redirect = 1'b0;
        step(E_FL, "redirect_flush2");
        step(E_FL, "redirect_flush3");
        clear_inputs();
        step(NONE, "redirect_done");

        // Redirect held through a memory stall fires on release.
        set_ex(OP_BRANCH, 0);
        hz.ex_redirect      = 1'b1;
        hz.mem_load_pending = 1'b1;
        step(E_MS, "defer_stall1");
        step(E_MS, "defer_stall2");
        hz.mem_rvalid = 1'b1;
        step(E_RD, "defer_release_fire");
        clear_inputs();
        step(E_FL, "defer_flush2");
        step(E_FL, "defer_flush3");
        step(NONE, "defer_done");

        // Memory stall in the middle of a flush resumes the flush.
        set_ex(OP_JAL, 1);
        hz.ex_redirect = 1'b1;
        step(E_RD, "flushstall_fire");
        clear_inputs();
        hz.mem_load_pending = 1'b1;
        step(E_MS, "flushstall_stall");
        hz.mem_rvalid = 1'b1;
        step(E_FL, "flushstall_resume2");
        clear_inputs();
        step(E_FL, "flushstall_resume3");
        step(NONE, "flushstall_done");

        // Timeout: error after 8 stalled cycles, sticky.
        hz.mem_load_pending = 1'b1;
        for (int unsigned i = 0; i < 8; i++) step(E_MS, "timeout_pre");
        for (int unsigned i = 0; i < 2; i++) step(E_MS | ER, "timeout_set");
        hz.mem_load_pending = 1'b0;
        step(ER, "timeout_sticky");
        hz.mem_load_pending = 1'b1;
        step(E_MS | ER, "timeout_restall");

        // Reset in the middle of a stall.
        rst = 1'b1;
        step(NONE, "rst_mid_stall");
        rst = 1'b0;
        hz.mem_load_pending = 1'b0;
        step(NONE, "post_rst_clear");
        set_ex(OP_LOAD, 7);
        set_dec(0, 1'b0, 7, 1'b1);
        step(E_LU, "post_rst_run");
        clear_inputs();
        step(NONE, "post_rst_bubble");

`ifdef HAZARD_PERF_COUNTERS_EN
        checks++;
        assert (perf_stall_cycles === 32'(exp_stall)) else begin
            failures++;
            $error("FAIL perf_stall: observed=%0d expected=%0d", perf_stall_cycles, exp_stall);
        end
        checks++;
        assert (perf_bubbles === 32'(exp_bub)) else begin
            failures++;
            $error("FAIL perf_bubbles: observed=%0d expected=%0d", perf_bubbles, exp_bub);
        end
        checks++;
        assert (perf_flushes === 32'(exp_fl)) else begin
            failures++;
            $error("FAIL perf_flushes: observed=%0d expected=%0d", perf_flushes, exp_fl);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
